// File: rtl/sha_job_sched.sv
// rtl/sha_job_sched.sv - descriptor FIFO plus launch/run/report sequencer for the SHA transform core
// Optional watchdog enabled by defining SHA_SCHED_TIMEOUT_EN.
module sha_job_sched #(
    parameter int QDEPTH     = 4,
    parameter int RST_CYCLES = 2,
    parameter int MAX_WORDS  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [63:0] job_read_base,
    input  logic [63:0] job_write_base,
    input  logic [63:0] job_num,
    input  logic [63:0] job_stride,
    output logic        core_reset,
    output logic [63:0] core_read_base,
    output logic [63:0] core_write_base,
    output logic [63:0] core_num_read,
    output logic [63:0] core_read_size,
    input  logic        core_done,
    input  logic [31:0] timeout_limit,
    output logic        stat_valid,
    input  logic        stat_ready,
    output logic [7:0]  stat_id,
    output logic        stat_err,
    output logic        stat_timeout,
    output logic [31:0] stat_cycles,
    output logic        busy,
    output logic [31:0] jobs_done
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;
    typedef struct packed {
        logic [63:0] read_base;
        logic [63:0] write_base;
        logic [63:0] num;
        logic [63:0] stride;
    } desc_t;

    desc_t fifo_mem [QDEPTH];
    desc_t head;
    logic  enq, deq;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      rst_cnt_q, rst_cnt_d, cyc_q, cyc_d, jobs_done_q, jobs_done_d;
    logic [7:0]       id_q, id_d, stat_id_q, stat_id_d;
    logic             core_reset_q, core_reset_d, stat_valid_q, stat_valid_d;
    logic             stat_err_q, stat_err_d, stat_timeout_q, stat_timeout_d;
    logic [31:0]      stat_cycles_q, stat_cycles_d;
    logic [63:0]      core_rb_q, core_rb_d, core_wb_q, core_wb_d;
    logic [63:0]      core_num_q, core_num_d, core_size_q, core_size_d;

`ifndef SHA_SCHED_TIMEOUT_EN
    logic [31:0] unused_timeout_limit;
    assign unused_timeout_limit = timeout_limit;
`endif

    assign job_ready       = (count_q != FULL_CNT);
    assign busy            = (state_q != IDLE) || (count_q != '0);
    assign core_reset      = core_reset_q;
    assign core_read_base  = core_rb_q;
    assign core_write_base = core_wb_q;
    assign core_num_read   = core_num_q;
    assign core_read_size  = core_size_q;
    assign stat_valid      = stat_valid_q;
    assign stat_id         = stat_id_q;
    assign stat_err        = stat_err_q;
    assign stat_timeout    = stat_timeout_q;
    assign stat_cycles     = stat_cycles_q;
    assign jobs_done       = jobs_done_q;

    always_ff @(posedge clk) begin
        if (enq) fifo_mem[wr_ptr_q] <= '{job_read_base, job_write_base, job_num, job_stride};
    end

    always_comb begin
        enq      = job_valid && job_ready;
        deq      = (state_q == IDLE) && (count_q != '0);
        head     = fifo_mem[rd_ptr_q];
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};

        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        cyc_d          = cyc_q;
        id_d           = id_q;
        jobs_done_d    = jobs_done_q;
        core_reset_d   = core_reset_q;
        core_rb_d      = core_rb_q;
        core_wb_d      = core_wb_q;
        core_num_d     = core_num_q;
        core_size_d    = core_size_q;
        stat_valid_d   = stat_valid_q;
        stat_id_d      = stat_id_q;
        stat_err_d     = stat_err_q;
        stat_timeout_d = stat_timeout_q;
        stat_cycles_d  = stat_cycles_q;

        case (state_q)
            IDLE: begin
                core_reset_d = 1'b1;
                if (deq) begin
                    core_rb_d      = head.read_base;
                    core_wb_d      = head.write_base;
                    core_num_d     = head.num;
                    core_size_d    = head.stride;
                    stat_id_d      = id_q;
                    id_d           = id_q + 8'd1;
                    stat_timeout_d = 1'b0;
                    stat_cycles_d  = '0;
                    rst_cnt_d      = '0;
                    // Illegal sizes are reported straight away; the core never leaves reset.
                    if ((head.num == '0) || (head.num > 64'(MAX_WORDS))) begin
                        stat_err_d   = 1'b1;
                        stat_valid_d = 1'b1;
                        state_d      = REPORT;
                    end else begin
                        stat_err_d = 1'b0;
                        state_d    = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                if (rst_cnt_q == RST_LAST) begin
                    core_reset_d = 1'b0;
                    cyc_d        = 32'd1;
                    state_d      = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end
            RUN: begin
                if (core_done) begin
                    stat_cycles_d  = cyc_q;
                    stat_timeout_d = 1'b0;
                    core_reset_d   = 1'b1;
                    stat_valid_d   = 1'b1;
                    state_d        = REPORT;
                end
`ifdef SHA_SCHED_TIMEOUT_EN
                else if ((timeout_limit != '0) && (cyc_q == timeout_limit)) begin
                    stat_cycles_d  = timeout_limit;
                    stat_timeout_d = 1'b1;
                    core_reset_d   = 1'b1;
                    stat_valid_d   = 1'b1;
                    state_d        = REPORT;
                end
`endif
                else if (cyc_q != '1) begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            REPORT: begin
                if (stat_ready) begin
                    stat_valid_d = 1'b0;
                    jobs_done_d  = jobs_done_q + 32'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rst_cnt_q      <= '0;
            cyc_q          <= '0;
            id_q           <= '0;
            jobs_done_q    <= '0;
            core_reset_q   <= 1'b1;
            core_rb_q      <= '0;
            core_wb_q      <= '0;
            core_num_q     <= '0;
            core_size_q    <= '0;
            stat_valid_q   <= 1'b0;
            stat_id_q      <= '0;
            stat_err_q     <= 1'b0;
            stat_timeout_q <= 1'b0;
            stat_cycles_q  <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rst_cnt_q      <= rst_cnt_d;
            cyc_q          <= cyc_d;
            id_q           <= id_d;
            jobs_done_q    <= jobs_done_d;
            core_reset_q   <= core_reset_d;
            core_rb_q      <= core_rb_d;
            core_wb_q      <= core_wb_d;
            core_num_q     <= core_num_d;
            core_size_q    <= core_size_d;
            stat_valid_q   <= stat_valid_d;
            stat_id_q      <= stat_id_d;
            stat_err_q     <= stat_err_d;
            stat_timeout_q <= stat_timeout_d;
            stat_cycles_q  <= stat_cycles_d;
        end
    end
endmodule

// File: tb/tb_sha_job_sched.sv
// tb/tb_sha_job_sched.sv - scoreboard bench for sha_job_sched with a behavioural core model
module tb_sha_job_sched;
    localparam int RST_CYCLES = 2;
    localparam int MAX_WORDS  = 32;
`ifdef SHA_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        job_valid = 1'b0, job_ready;
    logic [63:0] job_read_base = '0, job_write_base = '0, job_num = '0, job_stride = '0;
    logic        core_reset, core_done = 1'b0;
    logic [63:0] core_read_base, core_write_base, core_num_read, core_read_size;
    logic [31:0] timeout_limit = '0;
    logic        stat_valid, stat_ready = 1'b1;
    logic [7:0]  stat_id;
    logic        stat_err, stat_timeout;
    logic [31:0] stat_cycles, jobs_done;
    logic        busy;

    sha_job_sched #(.QDEPTH(4), .RST_CYCLES(RST_CYCLES), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_read_base(job_read_base), .job_write_base(job_write_base),
        .job_num(job_num), .job_stride(job_stride),
        .core_reset(core_reset), .core_read_base(core_read_base),
        .core_write_base(core_write_base), .core_num_read(core_num_read),
        .core_read_size(core_read_size), .core_done(core_done),
        .timeout_limit(timeout_limit),
        .stat_valid(stat_valid), .stat_ready(stat_ready), .stat_id(stat_id),
        .stat_err(stat_err), .stat_timeout(stat_timeout), .stat_cycles(stat_cycles),
        .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] rb, wb, num, stride; int delay; } job_t;
    typedef struct { logic [7:0] id; logic err, timeout; logic [31:0] cycles; } rec_t;

    rec_t exp_q[$];
    job_t core_q[$];
    int   n_checks = 0, n_fail = 0;
    int   acc_cnt = 0, hs_cnt = 0;
    int   cur_delay = 1;
    int   ready_mode = 0;
    bit   glitch_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected status record, straight from the job's size, its planned core latency and the watchdog limit.
    function automatic rec_t model(input logic [63:0] num, input int delay, input logic [31:0] limit, input int seq);
        rec_t r;
        r.id      = 8'(seq);
        r.err     = (num == 0) || (num > 64'(MAX_WORDS));
        r.timeout = 1'b0;
        r.cycles  = '0;
        if (!r.err) begin
            if (TO_EN && limit != 0 && (delay == 0 || longint'(delay) > longint'(limit))) begin
                r.timeout = 1'b1;
                r.cycles  = limit;
            end else begin
                r.cycles = 32'(delay);
            end
        end
        return r;
    endfunction

    logic held = 1'b0;
    rec_t held_rec, got_rec;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            acc_cnt = 0;
            hs_cnt  = 0;
            held    = 1'b0;
        end else begin
            check("jobs_done", 64'(jobs_done), 64'(hs_cnt));
            if (held) begin
                check("stat_valid_hold", 64'(stat_valid), 64'd1);
                check("stat_fields_hold", {22'd0, stat_id, stat_err, stat_timeout, stat_cycles},
                      {22'd0, held_rec.id, held_rec.err, held_rec.timeout, held_rec.cycles});
            end
            held = stat_valid && !stat_ready;
            held_rec.id = stat_id; held_rec.err = stat_err;
            held_rec.timeout = stat_timeout; held_rec.cycles = stat_cycles;
            if (stat_valid && stat_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_record: got id=%0d err=%0b expected no record", stat_id, stat_err);
                end else begin
                    got_rec = exp_q.pop_front();
                    check("stat_id", 64'(stat_id), 64'(got_rec.id));
                    check("stat_err", 64'(stat_err), 64'(got_rec.err));
                    check("stat_timeout", 64'(stat_timeout), 64'(got_rec.timeout));
                    check("stat_cycles", 64'(stat_cycles), 64'(got_rec.cycles));
                end
                hs_cnt++;
            end
            if (job_valid && job_ready) begin
                exp_q.push_back(model(job_num, cur_delay, timeout_limit, acc_cnt));
                if (job_num != 0 && job_num <= 64'(MAX_WORDS))
                    core_q.push_back('{job_read_base, job_write_base, job_num, job_stride, cur_delay});
                acc_cnt++;
            end
        end
    end

    // Core model: counts cycles out of reset, checks its config, pulses done after the job's latency.
    int   run_cnt = 0;
    job_t cj;
    always @(negedge clk) begin
        if (reset || core_reset) begin
            if (reset) core_q.delete();
            run_cnt   = 0;
            core_done = glitch_en && !reset && ($urandom_range(0, 7) == 0);
        end else begin
            run_cnt++;
            if (run_cnt == 1) begin
                if (core_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL core_run_unexpected: got core out of reset expected no legal job pending");
                    cj = '{64'd0, 64'd0, 64'd0, 64'd0, 0};
                end else begin
                    cj = core_q.pop_front();
                end
            end
            n_checks++;
            if ({core_read_base, core_write_base, core_num_read, core_read_size} !== {cj.rb, cj.wb, cj.num, cj.stride}) begin
                n_fail++;
                $display("FAIL core_cfg: got %0h/%0h/%0h/%0h expected %0h/%0h/%0h/%0h", core_read_base,
                         core_write_base, core_num_read, core_read_size, cj.rb, cj.wb, cj.num, cj.stride);
            end
            core_done = (cj.delay != 0) && (run_cnt == cj.delay);
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       stat_ready = 1'b1;
            1:       stat_ready = 1'($urandom_range(0, 1));
            default: stat_ready = 1'b0;
        endcase
    end

    task automatic send_job(input logic [63:0] rb, input logic [63:0] wb, input logic [63:0] num,
                            input logic [63:0] stride, input int delay);
        bit ok = 1'b0;
        job_read_base = rb; job_write_base = wb; job_num = num; job_stride = stride;
        cur_delay = delay;
        job_valid = 1'b1;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            ok = job_ready;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL job_accept: got job_ready=0 for 5000 cycles expected acceptance");
        end
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while ((exp_q.size() != 0 || busy) && i < 20000) begin
            @(negedge clk);
            i++;
        end
        n_checks++;
        if (exp_q.size() != 0 || busy) begin
            n_fail++;
            $display("FAIL drain: got %0d records outstanding busy=%0b expected 0 and idle", exp_q.size(), busy);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
    endtask

    initial begin
        int k;
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_job_ready", 64'(job_ready), 64'd1);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_stat_valid", 64'(stat_valid), 64'd0);
        check("rst_stat", {22'd0, stat_id, stat_err, stat_timeout, stat_cycles}, 64'd0);
        check("rst_core_cfg", core_read_base | core_write_base | core_num_read | core_read_size, 64'd0);
        check("rst_jobs_done", 64'(jobs_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1; reset = 1'b0;

        // Single job and launch latency: dequeue cycle plus RST_CYCLES of core_reset, then low.
        send_job(64'h100, 64'h200, 64'd4, 64'd4, 37);
        for (int i = 0; i <= RST_CYCLES; i++) begin
            @(negedge clk);
            check("launch_core_reset_hi", 64'(core_reset), 64'd1);
        end
        @(negedge clk);
        check("launch_core_reset_lo", 64'(core_reset), 64'd0);
        drain();
        check("jobs_done_first", 64'(jobs_done), 64'd1);

        // Back-to-back jobs behind a long-running one fill the FIFO.
        send_job(64'h1000, 64'h2000, 64'd8, 64'd8, 60);
        for (int n = 0; n < 4; n++)
            send_job(64'(n) << 12, 64'(n) << 16, 64'(n + 1), 64'd4, 5 + 3 * n);
        @(negedge clk);
        check("job_ready_full", 64'(job_ready), 64'd0);
        check("busy_full", 64'(busy), 64'd1);
        send_job(64'h5000, 64'h6000, 64'd32, 64'd8, 9);
        drain();

        // Illegal sizes reported without touching the core, then a legal one.
        send_job(64'h10, 64'h20, 64'd0, 64'd4, 7);
        send_job(64'h30, 64'h40, 64'd33, 64'd4, 7);
        send_job(64'h50, 64'h60, 64'd8, 64'd4, 12);
        drain();

        // Consumer stalls: record must hold and the next job must wait.
        ready_mode = 2;
        send_job(64'h70, 64'h80, 64'd2, 64'd4, 5);
        send_job(64'h90, 64'hA0, 64'd3, 64'd4, 6);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = stat_valid;
        end
        check("stall_record_seen", 64'(seen), 64'd1);
        repeat (10) @(negedge clk);
        check("stall_jobs_done", 64'(jobs_done), 64'(acc_cnt - exp_q.size()));
        check("stall_core_reset", 64'(core_reset), 64'd1);
        ready_mode = 0;
        drain();

        // Reset in the 5th RUN cycle with two jobs queued.
        send_job(64'h111, 64'h222, 64'd4, 64'd4, 100);
        send_job(64'h333, 64'h444, 64'd4, 64'd4, 10);
        send_job(64'h555, 64'h666, 64'd4, 64'd4, 10);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = !core_reset;
        end
        check("reset_test_run_seen", 64'(seen), 64'd1);
        repeat (4) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_job_ready", 64'(job_ready), 64'd1);
        check("midrst_core_reset", 64'(core_reset), 64'd1);
        check("midrst_stat_valid", 64'(stat_valid), 64'd0);
        check("midrst_jobs_done", 64'(jobs_done), 64'd0);
        repeat (30) @(negedge clk);
        check("midrst_still_idle", 64'(busy), 64'd0);

        // Watchdog: done exactly on the limit wins; never-done either times out or hangs.
        timeout_limit = 32'd50;
        send_job(64'h700, 64'h800, 64'd5, 64'd4, 50);
        drain();
        send_job(64'h900, 64'hA00, 64'd5, 64'd4, 0);
        if (TO_EN) begin
            drain();
        end else begin
            repeat (1100) @(negedge clk);
            check("hang_core_reset", 64'(core_reset), 64'd0);
            check("hang_busy", 64'(busy), 64'd1);
            check("hang_stat_valid", 64'(stat_valid), 64'd0);
            pulse_reset();
        end

        // Randomised traffic with a live watchdog, stalling consumer and stray done pulses.
        timeout_limit = 32'd40;
        ready_mode = 1;
        glitch_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            send_job(64'($urandom), 64'($urandom), 64'($urandom_range(0, 40)), 64'($urandom_range(1, 16)),
                     int'($urandom_range(1, 60)));
            k = int'($urandom_range(0, 6));
            repeat (k) @(posedge clk);
            #1;
        end
        drain();
        glitch_en = 1'b0;
        ready_mode = 0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
